// File: rtl/riscv_div_seq.sv
// riscv_div_seq: sequential radix-2 restoring divider for the EX stage.
// It executes ALU_DIVU/ALU_DIV/ALU_REMU/ALU_REM, one request at a time.
// Divide-by-zero and signed overflow go straight to DONE with a 1-cycle
// latency. Every other request takes 32 DIVIDE iterations, which gives a
// 33-cycle latency.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid_i   request valid; accepted only when in_ready_o is high (IDLE)
//   in_ready_o   high only in IDLE
//   operator_i   ALU operator; [6:2] must be 5'b01100, [0]=signed, [1]=remainder
//   op_a_i       dividend
//   op_b_i       divisor
//   kill_i       flush: abandons any operation and blocks acceptance
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  consumer accepts the result
//   result_o     quotient or remainder, registered
module riscv_div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [6:0]            operator_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic                  kill_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int                  CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [4:0]          DIV_GROUP = 5'b01100;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   rem_q;
  logic [DATA_WIDTH-1:0]   quo_q;
  logic [DATA_WIDTH-1:0]   div_q;
  logic                    signed_q;
  logic                    rem_sel_q;
  logic                    neg_q_q;
  logic                    neg_r_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    out_valid_q;
  logic                    in_ready_q;

  // Two's complement negation when requested.
  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic neg,
                                                   input logic [DATA_WIDTH-1:0] v);
    return neg ? (~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // ---------------- request decode (IDLE) ----------------
  logic                  is_div_op_d;
  logic                  sgn_in_d;
  logic                  b_zero_d;
  logic                  ovf_d;
  logic [DATA_WIDTH-1:0] abs_a_d;
  logic [DATA_WIDTH-1:0] abs_b_d;
  logic [DATA_WIDTH-1:0] fast_res_d;

  assign is_div_op_d = (operator_i[6:2] == DIV_GROUP);
  assign sgn_in_d    = operator_i[0];
  assign b_zero_d    = (op_b_i == '0);
  assign ovf_d       = sgn_in_d & (op_a_i == MIN_NEG) & (op_b_i == '1);
  assign abs_a_d     = neg_if(sgn_in_d & op_a_i[DATA_WIDTH-1], op_a_i);
  assign abs_b_d     = neg_if(sgn_in_d & op_b_i[DATA_WIDTH-1], op_b_i);
  // Special-case results are already in their final signed form.
  assign fast_res_d  = operator_i[1] ? (b_zero_d ? op_a_i : '0)
                                     : (b_zero_d ? '1 : MIN_NEG);

  // ---------------- one restoring iteration (DIVIDE) ----------------
  // rem_q < div_q always holds, so the shifted value is below 2*div_q. The
  // 33-bit trial therefore fits, and its top bit is exactly the borrow.
  logic [DATA_WIDTH:0]   rem_shift_d;
  logic [DATA_WIDTH:0]   trial_d;
  logic [DATA_WIDTH-1:0] rem_d;
  logic [DATA_WIDTH-1:0] quo_d;
  logic [DATA_WIDTH-1:0] res_d;

  assign rem_shift_d = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial_d     = rem_shift_d - {1'b0, div_q};
  assign rem_d       = trial_d[DATA_WIDTH] ? rem_shift_d[DATA_WIDTH-1:0]
                                           : trial_d[DATA_WIDTH-1:0];
  assign quo_d       = {quo_q[DATA_WIDTH-2:0], ~trial_d[DATA_WIDTH]};
  assign res_d       = rem_sel_q ? neg_if(neg_r_q, rem_d) : neg_if(neg_q_q, quo_d);

  // ---------------- control FSM and registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      signed_q    <= 1'b0;
      rem_sel_q   <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (kill_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && is_div_op_d) begin
            signed_q   <= sgn_in_d;
            rem_sel_q  <= operator_i[1];
            neg_q_q    <= sgn_in_d & (op_a_i[DATA_WIDTH-1] ^ op_b_i[DATA_WIDTH-1]) & ~b_zero_d;
            neg_r_q    <= sgn_in_d & op_a_i[DATA_WIDTH-1];
            div_q      <= abs_b_d;
            in_ready_q <= 1'b0;
            if (b_zero_d || ovf_d) begin
              result_q    <= fast_res_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q   <= CNT_W'(DATA_WIDTH - 1);
              rem_q   <= '0;
              quo_q   <= abs_a_d;
              state_q <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            result_q    <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_riscv_div_seq.sv
// tb_riscv_div_seq: directed plus randomized bench for riscv_div_seq. A
// RISC-V arithmetic reference model supplies the expected results.
module tb_riscv_div_seq;

  localparam logic [6:0] DIVU = 7'h30;
  localparam logic [6:0] DIV  = 7'h31;
  localparam logic [6:0] REMU = 7'h32;
  localparam logic [6:0] REM  = 7'h33;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  riscv_div_seq #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .operator_i  (op),
    .op_a_i      (a),
    .op_b_i      (b),
    .kill_i      (kill),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics written with plain arithmetic.
  function automatic logic [31:0] model(input logic [6:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    if (o[0]) return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic int model_lat(input logic [6:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
    if (y == 32'd0) return 1;
    if (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one cycle; the edge inside is the accept edge.
  task automatic issue(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [6:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int bp);
    int          lat;
    logic [31:0] exp;
    exp = model(o, x, y);
    issue(o, x, y);
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_result(tag, lat);
    chk({tag, "_lat"}, lat, model_lat(o, x, y));
    chk({tag, "_res"}, res, exp);
    for (int i = 0; i < bp; i++) begin
      step();
      chk({tag, "_bp_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_bp_res"}, res, exp);
      chk({tag, "_bp_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_hs_vld"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_hs_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    int          seen;
    int          sel;
    logic [6:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 7'd0;
    a         = 32'd0;
    b         = 32'd0;
    kill      = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    rst = 1'b0;
    step();

    // Directed cases.
    run_op("div100_7", DIV, 32'd100, 32'd7, 0);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("remu_m7_2", REMU, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_by0", DIVU, 32'h1234, 32'd0, 0);
    run_op("rem_by0", REM, 32'h1234, 32'd0, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_max", DIVU, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("divu_nonovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("bp10", DIV, 32'hFFFF_F000, 32'd13, 10);

    // A non-divide operator is ignored.
    op       = 7'h00;
    a        = 32'd9;
    b        = 32'd3;
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    chk("badop_rdy", {31'd0, in_ready}, 32'd1);
    chk("badop_vld", {31'd0, out_valid}, 32'd0);

    // kill_i in IDLE blocks acceptance.
    op       = DIV;
    in_valid = 1'b1;
    kill     = 1'b1;
    step();
    in_valid = 1'b0;
    kill     = 1'b0;
    chk("killidle_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("killidle_vld", {31'd0, out_valid}, 32'd0);

    // kill_i partway through DIVIDE.
    issue(DIV, 32'd100, 32'd7);
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_vld", {31'd0, out_valid}, 32'd0);
    chk("kill_rdy", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    chk("kill_noresult", seen, 0);
    run_op("div9_3", DIV, 32'd9, 32'd3, 0);

    // kill_i in DONE drops the result.
    issue(DIVU, 32'h1234, 32'd0);
    chk("killdone_pre", {31'd0, out_valid}, 32'd1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("killdone_vld", {31'd0, out_valid}, 32'd0);
    chk("killdone_rdy", {31'd0, in_ready}, 32'd1);

    // A request that arrives in the handshake cycle is not taken.
    issue(DIVU, 32'd50, 32'd5);
    wait_result("hsnew", lat);
    chk("hsnew_res", res, 32'd10);
    op        = DIV;
    a         = 32'd9;
    b         = 32'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("hsnew_rdy", {31'd0, in_ready}, 32'd1);
    chk("hsnew_vld", {31'd0, out_valid}, 32'd0);
    step();
    chk("hsnew_idle", {31'd0, in_ready}, 32'd1);

    // rst in the middle of DIVIDE.
    run_op("pre_rst", DIV, 32'd77, 32'd7, 0);
    issue(DIV, 32'd100, 32'd7);
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
    chk("midrst_vld", {31'd0, out_valid}, 32'd0);
    chk("midrst_res", res, 32'd0);
    rst = 1'b0;
    step();
    run_op("post_rst", REMU, 32'd1000, 32'd33, 0);

    // Randomized operations.
    for (int n = 0; n < 60; n++) begin
      ro  = {5'b01100, 2'($urandom_range(0, 3))};
      sel = $urandom_range(0, 5);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 40); end
        3: rb = $urandom_range(1, 255) | (rb & 32'h8000_0000);
        default: ;
      endcase
      run_op("rand", ro, ra, rb, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
